date_counter: RTL and testbench
===============================

DATE_COUNTER -- requirements
Module: date_counter

Interface
REQ-001 Parameter YEAR_W, default 14, SHALL set the year register width.
REQ-002 Parameter YEAR_INIT, default 2000, SHALL set the year loaded at reset.
REQ-003 Parameter YEAR_MAX, default 9999, SHALL set the last valid year, with YEAR_MAX < 2**YEAR_W.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 day_tick  input  1  SHALL be a one-cycle pulse requesting an advance of one calendar day.
REQ-007 mode  input  1  SHALL select run (0) or set (1) operation, synchronous and level-sensitive.
REQ-008 sel_next  input  1  SHALL be a one-cycle, pre-debounced pulse that advances the edited field.
REQ-009 inc  input  1  SHALL be a one-cycle, pre-debounced pulse that increments the edited field.
REQ-010 day  output  5  SHALL carry the day of month, 1..31.
REQ-011 month  output  4  SHALL carry the month, 1..12.
REQ-012 year  output  YEAR_W  SHALL carry the year, 0..YEAR_MAX.
REQ-013 sel  output  2  SHALL encode the FSM state: 0 RUN, 1 SET_DAY, 2 SET_MONTH, 3 SET_YEAR.
REQ-014 leap  output  1  SHALL be high when the current year is a leap year (combinational from the year register).
REQ-015 year_wrap  output  1  SHALL pulse high for one cycle when the year wraps from YEAR_MAX to 0.

Function
REQ-016 The leap rule SHALL be Gregorian: divisible by 4 and not by 100, or divisible by 400.
REQ-017 Month length SHALL be 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for February when leap is high; 28 otherwise.
REQ-018 In RUN, day_tick SHALL update day/month/year on the next rising edge (latency 1 cycle).
REQ-019 In RUN, a tick with day below the month length SHALL increment day by 1.
REQ-020 In RUN, a tick on the last day of months 1..11 SHALL set day=1 and increment month by 1.
REQ-021 In RUN, a tick on 31 December SHALL set day=1, month=1 and increment year by 1.
REQ-022 A year increment from YEAR_MAX, whether in RUN or in SET_YEAR, SHALL set year=0 and assert year_wrap for one cycle.
REQ-023 FSM transitions:
- RUN -> SET_DAY when mode=1.
- SET_DAY -> SET_MONTH -> SET_YEAR -> SET_DAY on each sel_next.
- Any SET_* state -> RUN when mode=0, with higher priority than sel_next.
REQ-024 In any SET_* state, day_tick SHALL be ignored (ticks are dropped, not queued).
REQ-025 In a SET_* state, inc SHALL act on the selected field only:
- SET_DAY: day wraps from the month length to 1.
- SET_MONTH: month wraps from 12 to 1; no carry into year.
- SET_YEAR: year increments per REQ-022.
REQ-026 After a month or year edit, day SHALL be clamped to the new month length in the same clock edge (e.g. 31 Jan + month inc -> 28/29 Feb).
REQ-027 When inc and sel_next arrive together, inc SHALL apply to the field selected before the edge, and sel SHALL then advance.
REQ-028 When mode rises in the same cycle as day_tick, the tick SHALL still be applied, because the state is RUN during that cycle.
REQ-029 inc and sel_next SHALL be ignored in RUN.

Reset
REQ-030 While rst_n is low, the outputs SHALL hold: day=1, month=1, year=YEAR_INIT, sel=0 (RUN), year_wrap=0; leap reflects YEAR_INIT.
REQ-031 Reset asserted mid-operation SHALL take effect immediately, regardless of clk.
REQ-032 After rst_n deasserts, the first state update SHALL occur on the first rising edge.

Verification
REQ-033 Bench SHALL cover: year 2024, 28 Feb, RUN, one tick -> 29 Feb, leap=1; next tick -> 1 Mar.
REQ-034 Bench SHALL cover: year 1900, 28 Feb, one tick -> 1 Mar, leap=0; year 2000, 28 Feb, one tick -> 29 Feb.
REQ-035 Bench SHALL cover: 31 Dec YEAR_MAX=9999, one tick -> 1 Jan year 0, year_wrap high for exactly one cycle.
REQ-036 Bench SHALL cover, set mode: mode=1, sel_next, inc on 31 Jan 2023 -> sel=2, 28 Feb 2023; then sel_next, inc -> 2024, day stays 28; day_tick pulses during this sequence leave the date unchanged.
REQ-037 Bench SHALL cover simultaneous inc+sel_next in SET_DAY on day 5 -> day 6, sel=2; mode=0 together with sel_next -> sel=0.
REQ-038 Bench SHALL cover reset asserted between clock edges in SET_YEAR -> outputs immediately return to 1/1/YEAR_INIT, sel=0.

Source files
------------

// File: rtl/date_counter.sv
// Calendar date counter (day/month/year) with a run mode driven by day ticks
// and a set mode that edits one field at a time. Gregorian leap rule.
module date_counter #(
  parameter int unsigned YEAR_W    = 14,
  parameter int unsigned YEAR_INIT = 2000,
  parameter int unsigned YEAR_MAX  = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              day_tick,
  input  logic              mode,
  input  logic              sel_next,
  input  logic              inc,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [1:0]        sel,
  output logic              leap,
  output logic              year_wrap
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SET_DAY   = 2'd1,
    ST_SET_MONTH = 2'd2,
    ST_SET_YEAR  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          day_q, day_d;
  logic [3:0]          month_q, month_d;
  logic [YEAR_W-1:0]   year_q, year_d;
  logic                wrap_q, wrap_d;

  logic                leap_cur;
  logic                leap_inc;
  logic                year_at_max;
  logic [YEAR_W-1:0]   year_inc;
  logic [3:0]          month_inc;
  logic [4:0]          len_cur;
  logic [4:0]          len_month_inc;
  logic [4:0]          len_year_inc;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic d4, d100, d400;
    d4   = (y[1:0] == 2'd0);
    d100 = ((y % YEAR_W'(100)) == '0);
    d400 = ((y % YEAR_W'(400)) == '0);
    return (d4 && !d100) || d400;
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      return lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  // Candidate increments and the month lengths they imply, shared by run and set paths.
  assign year_at_max   = (year_q == YEAR_W'(YEAR_MAX));
  assign year_inc      = year_at_max ? '0 : year_q + YEAR_W'(1);
  assign month_inc     = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
  assign leap_cur      = is_leap(year_q);
  assign leap_inc      = is_leap(year_inc);
  assign len_cur       = month_len(month_q, leap_cur);
  assign len_month_inc = month_len(month_inc, leap_cur);
  assign len_year_inc  = month_len(month_q, leap_inc);

  always_comb begin
    state_d = state_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    wrap_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (day_tick) begin
          if (day_q < len_cur) begin
            day_d = day_q + 5'd1;
          end else begin
            day_d = 5'd1;
            if (month_q == 4'd12) begin
              month_d = 4'd1;
              year_d  = year_inc;
              wrap_d  = year_at_max;
            end else begin
              month_d = month_q + 4'd1;
            end
          end
        end
        if (mode) state_d = ST_SET_DAY;
      end

      ST_SET_DAY: begin
        if (inc) day_d = (day_q >= len_cur) ? 5'd1 : day_q + 5'd1;
        if (!mode)         state_d = ST_RUN;
        else if (sel_next) state_d = ST_SET_MONTH;
      end

      ST_SET_MONTH: begin
        if (inc) begin
          month_d = month_inc;
          if (day_q > len_month_inc) day_d = len_month_inc;
        end
        if (!mode)         state_d = ST_RUN;
        else if (sel_next) state_d = ST_SET_YEAR;
      end

      ST_SET_YEAR: begin
        if (inc) begin
          year_d = year_inc;
          wrap_d = year_at_max;
          if (day_q > len_year_inc) day_d = len_year_inc;
        end
        if (!mode)         state_d = ST_RUN;
        else if (sel_next) state_d = ST_SET_DAY;
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= YEAR_W'(YEAR_INIT);
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      wrap_q  <= wrap_d;
    end
  end

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign sel       = state_q;
  assign leap      = leap_cur;
  assign year_wrap = wrap_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: leap rules, year wrap, set-mode edits,
// clamping, input collisions and asynchronous reset.
module tb_date_counter;

  localparam int unsigned YEAR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              day_tick = 1'b0;
  logic              mode = 1'b0;
  logic              sel_next = 1'b0;
  logic              inc = 1'b0;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic [1:0]        sel;
  logic              leap;
  logic              year_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  date_counter #(.YEAR_W(YEAR_W), .YEAR_INIT(2000), .YEAR_MAX(9999)) dut (
    .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .mode(mode),
    .sel_next(sel_next), .inc(inc), .day(day), .month(month), .year(year),
    .sel(sel), .leap(leap), .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y);
    check_eq({tag, ".day"},   32'(day),   32'(d));
    check_eq({tag, ".month"}, 32'(month), 32'(m));
    check_eq({tag, ".year"},  32'(year),  32'(y));
  endtask

  // Inputs change right after the falling edge; one full cycle per step.
  task automatic tick();
    day_tick = 1'b1; @(negedge clk); day_tick = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    if (n > 0) begin
      inc = 1'b1; repeat (n) @(negedge clk); inc = 1'b0;
    end
  endtask

  task automatic pulse_sel();
    sel_next = 1'b1; @(negedge clk); sel_next = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    mode = m; @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_date("rst", 1, 1, 2000);
    check_eq("rst.sel", 32'(sel), 32'd0);
    check_eq("rst.leap", 32'(leap), 32'd1);
    check_eq("rst.wrap", 32'(year_wrap), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // inc/sel_next ignored in RUN
    inc = 1'b1; sel_next = 1'b1; @(negedge clk); inc = 1'b0; sel_next = 1'b0;
    check_date("run_ign", 1, 1, 2000);
    check_eq("run_ign.sel", 32'(sel), 32'd0);
    tick();
    check_date("tick1", 2, 1, 2000);

    // 28 Feb 2024 -> 29 Feb -> 1 Mar
    set_mode(1'b1);
    check_eq("enter.sel", 32'(sel), 32'd1);
    pulse_inc(26); pulse_sel(); pulse_inc(1); pulse_sel(); pulse_inc(24);
    check_eq("y2024.sel", 32'(sel), 32'd3);
    set_mode(1'b0);
    check_date("feb28_2024", 28, 2, 2024);
    check_eq("y2024.leap", 32'(leap), 32'd1);
    tick();
    check_date("feb29_2024", 29, 2, 2024);
    tick();
    check_date("mar1_2024", 1, 3, 2024);

    // 31 Dec 9999 -> 1 Jan 0000 with one-cycle wrap
    set_mode(1'b1); pulse_sel(); pulse_inc(9); pulse_sel(); pulse_inc(7975);
    pulse_sel(); pulse_inc(30); set_mode(1'b0);
    check_date("dec31_9999", 31, 12, 9999);
    check_eq("y9999.leap", 32'(leap), 32'd0);
    check_eq("y9999.wrap", 32'(year_wrap), 32'd0);
    tick();
    check_date("wrap", 1, 1, 0);
    check_eq("wrap.pulse", 32'(year_wrap), 32'd1);
    check_eq("y0.leap", 32'(leap), 32'd1);
    @(negedge clk);
    check_eq("wrap.clear", 32'(year_wrap), 32'd0);

    // 1900: 28 Feb -> 1 Mar, not leap
    set_mode(1'b1); pulse_sel(); pulse_inc(1); pulse_sel(); pulse_inc(1900);
    check_eq("y1900.leap", 32'(leap), 32'd0);
    pulse_sel(); pulse_inc(27); set_mode(1'b0);
    tick();
    check_date("mar1_1900", 1, 3, 1900);

    // month wraps 12 -> 1 without year carry; 2000: 28 Feb -> 29 Feb
    set_mode(1'b1); pulse_sel(); pulse_inc(10);
    check_date("mwrap", 1, 1, 1900);
    pulse_inc(1); pulse_sel(); pulse_inc(100); pulse_sel(); pulse_inc(27);
    set_mode(1'b0);
    tick();
    check_date("feb29_2000", 29, 2, 2000);

    // Build 31 Jan 2023, then edit with clamping while ticks are dropped
    set_mode(1'b1); pulse_sel(); pulse_inc(11); pulse_sel(); pulse_inc(23);
    pulse_sel(); pulse_inc(2); set_mode(1'b0);
    check_date("jan31_2023", 31, 1, 2023);
    set_mode(1'b1); pulse_sel();
    check_eq("edit.sel2", 32'(sel), 32'd2);
    tick();
    check_date("drop1", 31, 1, 2023);
    pulse_inc(1);
    check_date("clamp_m", 28, 2, 2023);
    pulse_sel(); pulse_inc(1);
    check_date("clamp_y", 28, 2, 2024);
    check_eq("clamp_y.leap", 32'(leap), 32'd1);
    tick();
    check_date("drop2", 28, 2, 2024);

    // Day wrap in SET_DAY, then inc+sel_next and mode=0+sel_next collisions
    pulse_sel(); pulse_inc(1);
    check_eq("dinc29", 32'(day), 32'd29);
    pulse_inc(1);
    check_eq("dwrap", 32'(day), 32'd1);
    pulse_inc(4);
    inc = 1'b1; sel_next = 1'b1; @(negedge clk); inc = 1'b0; sel_next = 1'b0;
    check_eq("both.day", 32'(day), 32'd6);
    check_eq("both.sel", 32'(sel), 32'd2);
    mode = 1'b0; sel_next = 1'b1; @(negedge clk); sel_next = 1'b0;
    check_eq("exit.sel", 32'(sel), 32'd0);
    check_eq("exit.day", 32'(day), 32'd6);

    // Tick in the same cycle mode rises still applies
    day_tick = 1'b1; mode = 1'b1; @(negedge clk); day_tick = 1'b0;
    check_date("tick_mode", 7, 2, 2024);
    check_eq("tick_mode.sel", 32'(sel), 32'd1);

    // Asynchronous reset between edges while in SET_YEAR
    pulse_sel(); pulse_sel();
    check_eq("pre_rst.sel", 32'(sel), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_date("async_rst", 1, 1, 2000);
    check_eq("async_rst.sel", 32'(sel), 32'd0);
    check_eq("async_rst.wrap", 32'(year_wrap), 32'd0);
    check_eq("async_rst.leap", 32'(leap), 32'd1);
    mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_date("post_rst", 2, 1, 2000);
    check_eq("post_rst.sel", 32'(sel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
